// File: rtl/fft_loader_pkg.sv
// Shared types and helpers for the FFT sample loader: FSM state encoding,
// fill-order constants and the address bit-reversal function.
package fft_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        WAIT_RDY
    } loader_state_t;

    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_ILV = 1'b1;

    // Widest bank address the loader supports (BANK_DEPTH up to 4096).
    localparam int MAX_ADDR_W = 12;

    // Reverses the low 'width' bits of addr; bits above 'width' come back zero.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    width
    );
        logic [MAX_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < width) begin
                r[i] = addr[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_map.sv
// Maps sample index k and fill order to a one-hot bank enable and bank address.
// Define FFT_LOADER_BITREV_EN to bit-reverse the bank address for the FFT core.
module fft_addr_map
    import fft_loader_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int K_W       = 11,
    parameter int ADDR_W    = 9
) (
    input  logic [K_W-1:0]       k_i,
    input  logic                 mode_i,
    output logic [NUM_BANKS-1:0] we_oh_o,
    output logic [ADDR_W-1:0]    addr_o
);
    localparam int BANK_LOG = $clog2(NUM_BANKS);

    logic [K_W-1:0]    bank_idx;
    logic [ADDR_W-1:0] addr_nat;

    always_comb begin
        bank_idx = '0;
        addr_nat = '0;
        if (mode_i == MODE_ILV) begin
            bank_idx = k_i & K_W'(NUM_BANKS - 1);
            addr_nat = ADDR_W'(k_i >> BANK_LOG);
        end else begin
            bank_idx = k_i >> ADDR_W;
            addr_nat = k_i[ADDR_W-1:0];
        end
    end

    always_comb begin
        we_oh_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            we_oh_o[b] = (bank_idx == K_W'(b));
        end
    end

`ifdef FFT_LOADER_BITREV_EN
    assign addr_o = ADDR_W'(bitrev(MAX_ADDR_W'(addr_nat), ADDR_W));
`else
    assign addr_o = addr_nat;
`endif

endmodule

// File: rtl/fft_sample_loader.sv
// Streams ADC samples into the FFT core's banked input RAM and sequences the
// start/ready handshake. Bank address reversal is enabled by FFT_LOADER_BITREV_EN.
//
// state    | meaning
// IDLE     | waiting for iARM
// LOAD     | accepting samples, one write per accepted sample
// FLUSH    | last write of the frame on oWE
// START    | one-cycle start pulse to the FFT core
// WAIT_RDY | waiting for a rising edge on the core's ready
module fft_sample_loader
    import fft_loader_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 512
) (
    input  logic                          iCLK,
    input  logic                          iRESET,
    input  logic                          iARM,
    input  logic                          iMODE,
    input  logic [DATA_W-1:0]             iDATA,
    input  logic                          iVALID,
    output logic                          oREADY,
    output logic [DATA_W-1:0]             oDATA,
    output logic [$clog2(BANK_DEPTH)-1:0] oADDR_WR,
    output logic [NUM_BANKS-1:0]          oWE,
    output logic                          oSTART,
    input  logic                          iFFT_RDY,
    output logic                          oBUSY,
    output logic                          oDONE
);
    localparam int ADDR_W = $clog2(BANK_DEPTH);
    localparam int N      = NUM_BANKS * BANK_DEPTH;
    localparam int K_W    = $clog2(N);
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    loader_state_t state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic                 mode_q, mode_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_BANKS-1:0] we_q, we_d;
    logic                 rdy_q, rdy_prev_q;

    logic                 accept;
    logic                 rdy_rise;
    logic [NUM_BANKS-1:0] map_we;
    logic [ADDR_W-1:0]    map_addr;

    fft_addr_map #(
        .NUM_BANKS (NUM_BANKS),
        .K_W       (K_W),
        .ADDR_W    (ADDR_W)
    ) u_addr_map (
        .k_i     (k_q),
        .mode_i  (mode_q),
        .we_oh_o (map_we),
        .addr_o  (map_addr)
    );

    // Edge detect on the registered ready so a level left high by the previous
    // frame does not complete the current one.
    assign rdy_rise = rdy_q & ~rdy_prev_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= IDLE;
            k_q        <= '0;
            mode_q     <= MODE_SEQ;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            rdy_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            rdy_q      <= iFFT_RDY;
            rdy_prev_q <= rdy_q;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iARM) begin
                    state_d = LOAD;
                    mode_d  = iMODE;
                    k_d     = '0;
                end
            end
            LOAD: begin
                if (iVALID) begin
                    accept = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = FLUSH;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            FLUSH:    state_d = START;
            START:    state_d = WAIT_RDY;
            WAIT_RDY: begin
                if (rdy_rise) begin
                    if (iARM) begin
                        state_d = LOAD;
                        mode_d  = iMODE;
                        k_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        we_d   = '0;
        if (accept) begin
            data_d = iDATA;
            addr_d = map_addr;
            we_d   = map_we;
        end
    end

    assign oREADY   = (state_q == LOAD);
    assign oSTART   = (state_q == START);
    assign oBUSY    = (state_q != IDLE);
    assign oDONE    = (state_q == WAIT_RDY) && rdy_rise;
    assign oDATA    = data_q;
    assign oADDR_WR = addr_q;
    assign oWE      = we_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares them and tracks start/done pulses.
module tb_fft_sample_loader;
    localparam int DATA_W = 16;
    localparam int NB     = 4;
    localparam int BD     = 512;
    localparam int AW     = 9;
    localparam int N      = NB * BD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0;
    logic              mode = 1'b0;
    logic              valid = 1'b0;
    logic              fft_rdy = 1'b0;
    logic [DATA_W-1:0] din = '0;

    logic              o_ready, o_start, o_busy, o_done;
    logic [DATA_W-1:0] o_data;
    logic [AW-1:0]     o_addr;
    logic [NB-1:0]     o_we;

    fft_sample_loader #(
        .DATA_W     (DATA_W),
        .NUM_BANKS  (NB),
        .BANK_DEPTH (BD)
    ) dut (
        .iCLK     (clk),
        .iRESET   (rst_n),
        .iARM     (arm),
        .iMODE    (mode),
        .iDATA    (din),
        .iVALID   (valid),
        .oREADY   (o_ready),
        .oDATA    (o_data),
        .oADDR_WR (o_addr),
        .oWE      (o_we),
        .oSTART   (o_start),
        .iFFT_RDY (fft_rdy),
        .oBUSY    (o_busy),
        .oDONE    (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                k;
        logic              m;
        logic [NB-1:0]     we;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic          m;
        int            k;
        logic [NB-1:0] we;
        int            addr;
    } dir_t;

    exp_t q[$];
    dir_t dirs[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_done = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int first_acc = 0;
    int last_acc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rev_bits(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (((v >> i) & 1) != 0) r |= (1 << (w - 1 - i));
        end
        return r;
    endfunction

    function automatic exp_t model(input int k, input logic m);
        exp_t e;
        int bank, a;
        if (m) begin
            bank = k % NB;
            a    = k / NB;
        end else begin
            bank = k / BD;
            a    = k % BD;
        end
`ifdef FFT_LOADER_BITREV_EN
        a = rev_bits(a, AW);
`endif
        e.k    = k;
        e.m    = m;
        e.we   = NB'(1 << bank);
        e.addr = AW'(a);
        e.data = DATA_W'(k);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_we != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_write_we", longint'(o_we), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write_we", longint'(o_we), longint'(e.we));
                    chk("write_addr", longint'(o_addr), longint'(e.addr));
                    chk("write_data", longint'(o_data), longint'(e.data));
                    foreach (dirs[i]) begin
                        if (dirs[i].m == e.m && dirs[i].k == e.k) begin
                            chk($sformatf("dir_we_m%0d_k%0d", e.m, e.k), longint'(o_we), longint'(dirs[i].we));
                            chk($sformatf("dir_addr_m%0d_k%0d", e.m, e.k), longint'(o_addr), longint'(dirs[i].addr));
                        end
                    end
                end
            end
            if (o_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic arm_frame(input logic m);
        arm  = 1'b1;
        mode = m;
        @(posedge clk); #1;
        arm  = 1'b0;
        mode = ~m;
        chk("ready_in_load", longint'(o_ready), 1);
    endtask

    task automatic send_frame(input logic m, input int nsamp, input bit gaps);
        for (int k = 0; k < nsamp; k++) begin
            valid = 1'b1;
            din   = DATA_W'(k);
            q.push_back(model(k, m));
            @(posedge clk); #1;
            valid = 1'b0;
            if (k == 0) first_acc = cyc;
            last_acc = cyc;
            if (gaps && k < nsamp - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_frame(input int start_before, input int frame_len,
                                input logic rearm, input logic next_mode);
        int t = 0;
        int rise_cyc;
        int done_before;
        while (n_start == start_before && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("start_count", n_start, start_before + 1);
        chk("start_latency", start_cyc - last_acc, 1);
        chk("frame_cycles", start_cyc - first_acc + 1, frame_len);
        chk("queue_drained", q.size(), 0);
        done_before = n_done;
        fft_rdy = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_while_rdy_low_or_held", n_done, done_before);
        arm     = rearm;
        mode    = next_mode;
        fft_rdy = 1'b1;
        rise_cyc = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("done_count", n_done, done_before + 1);
        chk("done_timing", done_cyc, rise_cyc + 1);
        chk("after_done_ready", longint'(o_ready), longint'(rearm));
        chk("after_done_busy", longint'(o_busy), longint'(rearm));
        arm  = 1'b0;
        mode = ~next_mode;
    endtask

    initial begin
        int sb;
`ifdef FFT_LOADER_BITREV_EN
        dirs.push_back('{1'b0, 1,   4'b0001, 256});
        dirs.push_back('{1'b0, 3,   4'b0001, 384});
        dirs.push_back('{1'b0, 512, 4'b0010, 0});
`else
        dirs.push_back('{1'b0, 0,    4'b0001, 0});
        dirs.push_back('{1'b0, 511,  4'b0001, 511});
        dirs.push_back('{1'b0, 512,  4'b0010, 0});
        dirs.push_back('{1'b0, 2047, 4'b1000, 511});
        dirs.push_back('{1'b1, 5,    4'b0010, 1});
        dirs.push_back('{1'b1, 2046, 4'b0100, 511});
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", longint'({o_ready, o_data, o_addr, o_we, o_start, o_busy, o_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fft_rdy = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", longint'(o_busy), 0);
        chk("idle_ready", longint'(o_ready), 0);

        // Frame A: sequential, continuous, re-arm straight into interleaved.
        arm_frame(1'b0);
        sb = n_start;
        send_frame(1'b0, N, 1'b0);
        finish_frame(sb, N + 1, 1'b1, 1'b1);

        // Frame B: interleaved, entered from WAIT_RDY; then back to IDLE.
        sb = n_start;
        send_frame(1'b1, N, 1'b0);
        finish_frame(sb, N + 1, 1'b0, 1'b0);

        // Frame C: sequential with a one-cycle gap between samples.
        arm_frame(1'b0);
        sb = n_start;
        send_frame(1'b0, N, 1'b1);
        finish_frame(sb, 2 * N, 1'b0, 1'b0);

        // Frame D: reset mid-frame at k=1000, then a clean frame.
        arm_frame(1'b0);
        sb = n_start;
        send_frame(1'b0, 1000, 1'b0);
        @(negedge clk); #1;
        chk("pre_reset_queue", q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", longint'({o_ready, o_data, o_addr, o_we, o_start, o_busy, o_done}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        arm_frame(1'b0);
        send_frame(1'b0, N, 1'b0);
        finish_frame(sb, N + 1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("total_starts", n_start, 4);
        chk("total_dones", n_done, 4);
        chk("final_busy", longint'(o_busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Streams ADC samples into the FFT core's banked input RAM. Generates the per-bank write address and one-hot write enables that the bench currently drives by hand.
- Issues the one-cycle start to the FFT core once a frame is complete, then waits for its ready before loading the next frame.
- Generalised in bank count, bank depth and sample width. Supports two fill orders, selected per frame.
- Sits between the ADC front end and fft_top's iADDR_WR_n/iWE_n/iDATA/iSTART/oRDY.

Parameters:
- DATA_W, 16, sample width in bits.
- NUM_BANKS, 4, number of RAM banks; power of two, 1..16.
- BANK_DEPTH, 512, words per bank; power of two, 4..4096.
- ADDR_W, $clog2(BANK_DEPTH), bank address width (derived, not overridden).

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-low reset.
- iARM  in  1  level; enables frame acquisition.
- iMODE  in  1  fill order: 0 = sequential (bank-major), 1 = interleaved (sample k to bank k mod NUM_BANKS).
- iDATA  in  DATA_W  ADC sample.
- iVALID  in  1  iDATA valid.
- oREADY  out  1  loader accepts a sample this cycle.
- oDATA  out  DATA_W  registered sample to RAM.
- oADDR_WR  out  ADDR_W  common bank write address.
- oWE  out  NUM_BANKS  one-hot bank write enable.
- oSTART  out  1  one-cycle start pulse to FFT core.
- iFFT_RDY  in  1  FFT core ready/done level.
- oBUSY  out  1  high from leaving IDLE until return to IDLE.
- oDONE  out  1  one-cycle pulse when the FFT finishes a frame.

Behaviour:
- Reset (iRESET=0, async): all outputs 0, state IDLE, sample counter 0, latched mode 0. Reset mid-frame discards the partial frame; no oSTART is issued.
- Frame size N = NUM_BANKS*BANK_DEPTH. Counter k has width $clog2(N) and counts 0..N-1.
- States: IDLE, LOAD, FLUSH, START, WAIT_RDY.
- IDLE: oREADY=0. If iARM=1 at a clock edge: go to LOAD, latch iMODE, clear k.
- LOAD: oREADY=1.
  - A sample is accepted on an edge with iVALID=1.
  - In the following cycle, for exactly one cycle: oDATA=iDATA, oWE=one-hot(bank), oADDR_WR=addr. Latency is 1 cycle.
  - Sequential mapping: bank=k/BANK_DEPTH, addr=k%BANK_DEPTH.
  - Interleaved mapping: bank=k%NUM_BANKS, addr=k/NUM_BANKS.
  - iVALID=0: no write, k holds; gaps are allowed.
  - When the accepted sample has k=N-1: oREADY drops at that same edge and the state goes to FLUSH.
  - iARM and iMODE are ignored during LOAD.
- FLUSH: one cycle; the last write is visible on oWE.
- START: oSTART=1 for one cycle, then go to WAIT_RDY.
- WAIT_RDY:
  - iFFT_RDY is registered. A rising edge (previous 0, current 1) completes the frame. This tolerates RDY still being high from the previous frame until the core deasserts it.
  - On completion: oDONE pulses one cycle. If iARM=1, go directly to LOAD (re-latch iMODE, k=0); otherwise go to IDLE.
  - iFFT_RDY high continuously with no rising edge: stay in WAIT_RDY.
- oWE is never multi-hot. oWE=0 whenever no write was accepted on the previous edge.
- oBUSY = state != IDLE.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined: the computed addr is bit-reversed across ADDR_W bits before driving oADDR_WR, giving the FFT core bit-reversed input order. Bank selection is unchanged.
- Not defined: natural order. No reversal logic is synthesised.

Decomposition:
- Shared package fft_loader_pkg holds:
  - state enum loader_state_t {IDLE, LOAD, FLUSH, START, WAIT_RDY};
  - mode constants MODE_SEQ=1'b0 and MODE_ILV=1'b1;
  - function bitrev(addr, width).
- One sub-module, fft_addr_map: combinational k/mode to {bank one-hot, addr}, including the optional bit reversal. The top level keeps the FSM, counter and output registers.

Test Plan:
- Sequential, defaults, iDATA=k, iVALID continuous:
  - k=0 → oWE=4'b0001, addr 0;
  - k=511 → oWE=4'b0001, addr 511;
  - k=512 → oWE=4'b0010, addr 0;
  - k=2047 → oWE=4'b1000, addr 511.
  - oSTART fires 2 cycles after the edge accepting k=2047.
- Interleaved:
  - k=5 → oWE=4'b0010, addr 1;
  - k=2046 → oWE=4'b0100, addr 511.
- FFT_LOADER_BITREV_EN defined, sequential: k=1 → addr 256; k=3 → addr 384; k=512 → oWE=4'b0010, addr 0.
- iVALID toggling 1/0 every cycle: 2048 writes with no duplicate and no skipped address; frame takes 4096 cycles.
- Handshake:
  - iFFT_RDY held 1 through START, then 0 for 10 cycles, then 1: exactly one oDONE, on the cycle after the 0→1 edge.
  - With iARM=1 the loader returns to LOAD; with iARM=0 it goes to IDLE and oBUSY=0.
- Reset asserted at k=1000 in LOAD: all outputs 0 immediately. After release with iARM=1, the first write goes to bank 0, addr 0, and no oSTART occurs until 2048 new samples.
